// File: rtl/fir_pkg.sv
// Shared constants for the FIR multiply-accumulate output path: widths,
// multiplier latency and accumulator state encoding.
package fir_pkg;

  localparam int PROD_W     = 59;
  localparam int ACC_W      = 64;
  localparam int OUT_W      = 24;
  localparam int FRAC_SHIFT = 34;
  localparam int MUL_LAT    = 4;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clamp of a wide
// signed accumulator down to a signed codec sample, with a clamp flag.
module fir_round_sat #(
  parameter int IN_W       = 64,
  parameter int OUT_W      = 24,
  parameter int FRAC_SHIFT = 34
) (
  input  logic signed [IN_W-1:0]  acc_i,
  output logic signed [OUT_W-1:0] res_o,
  output logic                    sat_o
);

  // One extra bit so adding the half-LSB can never wrap.
  localparam logic signed [IN_W:0] HALF =
    {{(IN_W-FRAC_SHIFT+1){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
  localparam logic signed [IN_W:0] MAXV =
    {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV =
    {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] a);
    logic signed [IN_W:0] sum;
    sum = $signed({a[IN_W-1], a}) + HALF;
    return sum >>> FRAC_SHIFT;
  endfunction

  logic signed [IN_W:0] r;

  always_comb begin
    r     = round_shift(acc_i);
    sat_o = 1'b0;
    res_o = r[OUT_W-1:0];
    if (r > MAXV) begin
      res_o = MAXV[OUT_W-1:0];
      sat_o = 1'b1;
    end else if (r < MINV) begin
      res_o = MINV[OUT_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac_acc.sv
// Frame accumulator behind the pipelined FIR multiplier: aligns frame tags to
// the product, sums one frame, rounds/saturates it. Option: FIR_MAC_ACC_SAT_STATUS_EN.
module fir_mac_acc
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tag_valid,
  input  logic                     tag_first,
  input  logic                     tag_last,
  input  logic signed [PROD_W-1:0] m,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     dout_valid,
  output logic                     busy,
  output logic                     err
`ifdef FIR_MAC_ACC_SAT_STATUS_EN
  ,
  output logic                     sat,
  output logic [15:0]              sat_cnt
`endif
);

  logic [MUL_LAT-1:0][2:0]  tag_q, tag_d;
  logic [0:0]               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     close_q, close_d;
  logic                     err_q, err_d;
  logic signed [OUT_W-1:0]  dout_q, dout_d;
  logic                     dout_valid_q, dout_valid_d;
  logic                     v_d, f_d, l_d;
  logic signed [ACC_W-1:0]  m_ext;
  logic signed [OUT_W-1:0]  rs_res;
  logic                     rs_sat;

  assign {v_d, f_d, l_d} = tag_q[MUL_LAT-1];
  assign m_ext = {{(ACC_W-PROD_W){m[PROD_W-1]}}, m};

  // Stage 0: tag delay line and accumulate/state update aligned with m.
  always_comb begin
    tag_d   = {tag_q[MUL_LAT-2:0], {tag_valid, tag_first, tag_last}};
    state_d = state_q;
    acc_d   = acc_q;
    close_d = 1'b0;
    err_d   = 1'b0;
    if (v_d) begin
      if (f_d) begin
        // A first inside an open frame drops the partial sum and restarts.
        acc_d   = m_ext;
        err_d   = (state_q == S_ACCUM);
        state_d = l_d ? S_IDLE : S_ACCUM;
        close_d = l_d;
      end else if (state_q == S_ACCUM) begin
        acc_d = acc_q + m_ext;
        if (l_d) begin
          state_d = S_IDLE;
          close_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  fir_round_sat #(
    .IN_W       (ACC_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_round_sat (
    .acc_i (acc_q),
    .res_o (rs_res),
    .sat_o (rs_sat)
  );

  // Stage 1: register the rounded result of the frame closed last cycle.
  always_comb begin
    dout_valid_d = close_q;
    dout_d       = close_q ? rs_res : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q        <= '0;
      state_q      <= S_IDLE;
      acc_q        <= '0;
      close_q      <= 1'b0;
      err_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      tag_q        <= tag_d;
      state_q      <= state_d;
      acc_q        <= acc_d;
      close_q      <= close_d;
      err_q        <= err_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == S_ACCUM);
  assign err        = err_q;

`ifdef FIR_MAC_ACC_SAT_STATUS_EN
  logic        sat_q, sat_d;
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_d     = close_q & rs_sat;
    sat_cnt_d = sat_cnt_q;
    if (close_q && rs_sat && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q     <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      sat_q     <= sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat     = sat_q;
  assign sat_cnt = sat_cnt_q;
`else
  logic sat_unused;
  assign sat_unused = rs_sat;
`endif

endmodule
